// File: rtl/ddr4_v2_2_20_mc_cas_arb_pkg.sv
// Shared types and helpers for the CAS arbiter: counter sizing, per-requester
// command attributes and the round-robin pick.
package mc_cas_pkg;

  localparam int             NREQ    = 4;
  localparam int             CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_SAT = 4'd15;
  localparam int             RK_W    = 2;

  typedef struct packed {
    logic            rd;
    logic [1:0]      group;
    logic [RK_W-1:0] rank;
  } cas_cmd_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  // Lowest offset from ptr wins, so iterate from the far end down.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] elig,
                                              input logic [1:0]      ptr);
    logic [NREQ-1:0] win;
    logic [1:0]      idx;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (elig[idx]) win = 4'b0001 << idx;
    end
    return win;
  endfunction

endpackage

// File: rtl/ddr4_v2_2_20_mc_cas_arb_timer.sv
// CAS spacing tracker: saturating since-counters plus last-issue attributes;
// combinational per-requester timing-OK, no backpressure of its own.
module ddr4_v2_2_20_mc_cas_timer
  import mc_cas_pkg::*;
#(
  parameter int TCCD_L = 2,
  parameter int TCCD_S = 1,
  parameter int TRTRS  = 2,
  parameter int TWTR_L = 4,
  parameter int TWTR_S = 2,
  parameter int TRTW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  cas_cmd_t [NREQ-1:0]  cmd_i,
  input  logic                 issue_i,
  input  cas_cmd_t             issue_cmd_i,
  output logic [NREQ-1:0]      tmg_ok_o
);

  logic [CNT_W-1:0] since_cas_q, since_rd_q, since_wr_q;
  logic [CNT_W-1:0] since_cas_d, since_rd_d, since_wr_d;
  logic [1:0]       last_group_q, last_wr_group_q;
  logic [RK_W-1:0]  last_rank_q, last_wr_rank_q;
  logic [CNT_W:0]   cas_gap, rd_gap, wr_gap;
  logic             rank_ok, dir_ok;

  assign since_cas_d = issue_i                      ? '0 : sat_inc(since_cas_q);
  assign since_rd_d  = (issue_i &&  issue_cmd_i.rd) ? '0 : sat_inc(since_rd_q);
  assign since_wr_d  = (issue_i && !issue_cmd_i.rd) ? '0 : sat_inc(since_wr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since_cas_q     <= CNT_SAT;
      since_rd_q      <= CNT_SAT;
      since_wr_q      <= CNT_SAT;
      last_group_q    <= '0;
      last_rank_q     <= '0;
      last_wr_group_q <= '0;
      last_wr_rank_q  <= '0;
    end else begin
      since_cas_q <= since_cas_d;
      since_rd_q  <= since_rd_d;
      since_wr_q  <= since_wr_d;
      if (issue_i) begin
        last_group_q <= issue_cmd_i.group;
        last_rank_q  <= issue_cmd_i.rank;
        if (!issue_cmd_i.rd) begin
          last_wr_group_q <= issue_cmd_i.group;
          last_wr_rank_q  <= issue_cmd_i.rank;
        end
      end
    end
  end

  // Gaps are the distance from the last issue to the candidate issue cycle.
  assign cas_gap = {1'b0, since_cas_q} + 5'd1;
  assign rd_gap  = {1'b0, since_rd_q}  + 5'd1;
  assign wr_gap  = {1'b0, since_wr_q}  + 5'd1;

  always_comb begin
    tmg_ok_o = '0;
    rank_ok  = 1'b0;
    dir_ok   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (cmd_i[i].rank != last_rank_q)
        rank_ok = (cas_gap >= 5'(TRTRS));
      else if (cmd_i[i].group == last_group_q)
        rank_ok = (cas_gap >= 5'(TCCD_L));
      else
        rank_ok = (cas_gap >= 5'(TCCD_S));

      if (cmd_i[i].rd) begin
        if (cmd_i[i].group == last_wr_group_q && cmd_i[i].rank == last_wr_rank_q)
          dir_ok = (wr_gap >= 5'(TWTR_L));
        else
          dir_ok = (wr_gap >= 5'(TWTR_S));
      end else begin
        dir_ok = (rd_gap >= 5'(TRTW));
      end

      tmg_ok_o[i] = rank_ok && dir_ok;
    end
  end

endmodule

// File: rtl/ddr4_v2_2_20_mc_cas_arb.sv
// Round-robin CAS arbiter over four group FSMs; one registered stage, request to
// grant is 1 cycle minimum; casStall or spacing rules simply withhold grants.
module ddr4_v2_2_20_mc_cas_arb
  import mc_cas_pkg::*;
#(
  parameter int RKBITS = RK_W,
  parameter int TCCD_L = 2,
  parameter int TCCD_S = 1,
  parameter int TRTRS  = 2,
  parameter int TWTR_L = 4,
  parameter int TWTR_S = 2,
  parameter int TRTW   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        casReq,
  input  logic [NREQ-1:0]        casRd,
  input  logic [2*NREQ-1:0]      casGroup,
  input  logic [RKBITS*NREQ-1:0] casRank,
  input  logic                   casStall,
  output logic [NREQ-1:0]        sel,
  output logic [NREQ-1:0]        grant,
  output logic                   casValid,
  output logic                   casIsRd
);

  cas_cmd_t [NREQ-1:0] cmd;
  cas_cmd_t            win_cmd;
  logic [NREQ-1:0]     tmg_ok, elig, sel_d, sel_q;
  logic [1:0]          rr_q, rr_d, win_idx;
  logic                issue, valid_q, rd_q;

  always_comb begin
    cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      cmd[i].rd    = casRd[i];
      cmd[i].group = casGroup[2*i +: 2];
      cmd[i].rank  = casRank[RKBITS*i +: RKBITS];
    end
  end

  // The requester being granted right now is masked so it cannot double-issue.
  assign elig  = casReq & ~sel_q & tmg_ok & {NREQ{~casStall}};
  assign sel_d = rr_pick(elig, rr_q);
  assign issue = |sel_d;

  always_comb begin
    win_cmd = '0;
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_d[i]) begin
        win_cmd = cmd[i];
        win_idx = 2'(i);
      end
    end
  end

  assign rr_d = issue ? win_idx + 2'd1 : rr_q;

  ddr4_v2_2_20_mc_cas_timer #(
    .TCCD_L (TCCD_L),
    .TCCD_S (TCCD_S),
    .TRTRS  (TRTRS),
    .TWTR_L (TWTR_L),
    .TWTR_S (TWTR_S),
    .TRTW   (TRTW)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_i       (cmd),
    .issue_i     (issue),
    .issue_cmd_i (win_cmd),
    .tmg_ok_o    (tmg_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      valid_q <= 1'b0;
      rd_q    <= 1'b0;
      rr_q    <= '0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= issue;
      rd_q    <= issue & win_cmd.rd;
      rr_q    <= rr_d;
    end
  end

  assign sel      = sel_q;
  assign grant    = sel_q;
  assign casValid = valid_q;
  assign casIsRd  = rd_q;

endmodule

// File: tb/tb_ddr4_v2_2_20_mc_cas_arb.sv
// Directed and randomized checks of the CAS arbiter against a cycle-stamp model
// of the DDR4 spacing rules and round-robin order.
module tb_ddr4_v2_2_20_mc_cas_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] casReq, casRd;
  logic [7:0] casGroup, casRank;
  logic       casStall;
  logic [3:0] sel, grant;
  logic       casValid, casIsRd;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: cycle stamps of the most recent issues.
  int         cyc;
  logic [3:0] m_sel;
  int         m_rr;
  int         t_cas, t_rd, t_wr;
  int         l_grp, l_rank, l_wgrp, l_wrank;

  ddr4_v2_2_20_mc_cas_arb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .casReq   (casReq),
    .casRd    (casRd),
    .casGroup (casGroup),
    .casRank  (casRank),
    .casStall (casStall),
    .sel      (sel),
    .grant    (grant),
    .casValid (casValid),
    .casIsRd  (casIsRd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_sel  = '0;
    m_rr   = 0;
    t_cas  = -100;
    t_rd   = -100;
    t_wr   = -100;
    l_grp  = 0;
    l_rank = 0;
    l_wgrp = 0;
    l_wrank = 0;
  endtask

  function automatic bit m_elig(input int i);
    int t, need, g, r;
    t = cyc + 1;
    g = casGroup[2*i +: 2];
    r = casRank[2*i +: 2];
    if (!casReq[i] || m_sel[i] || casStall) return 0;
    need = (r != l_rank) ? 2 : (g == l_grp) ? 2 : 1;
    if (t - t_cas < need) return 0;
    if (casRd[i]) begin
      need = (g == l_wgrp && r == l_wrank) ? 4 : 2;
      if (t - t_wr < need) return 0;
    end else if (t - t_rd < 3) begin
      return 0;
    end
    return 1;
  endfunction

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic step();
    logic [3:0] exp;
    logic       exp_rd;
    int         w;
    exp = '0;
    w   = -1;
    for (int k = 0; k < 4; k++) begin
      int i = (m_rr + k) % 4;
      if (w < 0 && m_elig(i)) w = i;
    end
    if (w >= 0) exp[w] = 1'b1;
    exp_rd = (w >= 0) ? casRd[w] : 1'b0;
    @(posedge clk);
    #1;
    chk("sel", sel, exp);
    chk("grant", grant, exp);
    chk("valid", casValid, (w >= 0));
    chk("isrd", casIsRd, exp_rd);
    cyc++;
    m_sel = exp;
    if (w >= 0) begin
      t_cas  = cyc;
      l_grp  = casGroup[2*w +: 2];
      l_rank = casRank[2*w +: 2];
      if (casRd[w]) t_rd = cyc;
      else begin
        t_wr    = cyc;
        l_wgrp  = l_grp;
        l_wrank = l_rank;
      end
      m_rr = (w + 1) % 4;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    casReq = '0;
    repeat (n) step();
  endtask

  task automatic run_until(input int idx, input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sel[idx] && n < maxc);
    if (!sel[idx]) chk("timeout", sel[idx], 1);
  endtask

  task automatic newcmd(input int i);
    casReq[i]         = 1'b1;
    casRd[i]          = 1'($urandom_range(0, 1));
    casGroup[2*i +: 2] = 2'($urandom_range(0, 3));
    casRank[2*i +: 2]  = 2'($urandom_range(0, 1));
  endtask

  initial begin
    int n;
    cyc = 0;
    m_reset();
    rst_n = 1'b0;
    casReq = '0; casRd = '0; casGroup = '0; casRank = '0; casStall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_grant", grant, 0);
    chk("rst_valid", casValid, 0);
    chk("rst_isrd", casIsRd, 0);
    rst_n = 1'b1;

    // First request after reset, then pointer lands on 3.
    casReq = 4'b0100; casRd = 4'b0100; casGroup = 8'b00_01_00_00; casRank = '0;
    step();
    chk("t1_sel", sel, 4'b0100);
    chk("t1_rd", casIsRd, 1);
    casReq = 4'b1001; casRd = 4'b1001; casGroup = 8'b00_01_00_11;
    step();
    chk("t1_rr3", sel, 4'b1000);
    casReq = 4'b0001;
    step();
    chk("t1_rr0", sel, 4'b0001);
    idle(16);

    // tCCD_L alternation between two readers of the same group.
    casReq = 4'b0011; casRd = 4'b1111; casGroup = 8'b10_10_10_10; casRank = '0;
    run_until(1, 8, n); chk("t2_first", n, 1);
    run_until(0, 8, n); chk("t2_ccdl_a", n, 2);
    run_until(1, 8, n); chk("t2_ccdl_b", n, 2);
    run_until(0, 8, n); chk("t2_ccdl_c", n, 2);
    idle(16);

    // Write then read: same group (tWTR_L) and other group (tWTR_S).
    casReq = 4'b0001; casRd = 4'b0000; casGroup = '0; casRank = '0;
    run_until(0, 8, n);
    casReq = 4'b0010; casRd = 4'b0010;
    run_until(1, 12, n); chk("t3_wtr_l", n, 4);
    idle(16);
    casReq = 4'b0001; casRd = 4'b0000;
    run_until(0, 8, n);
    casReq = 4'b0010; casRd = 4'b0010; casGroup = 8'b00_00_11_00;
    run_until(1, 12, n); chk("t3_wtr_s", n, 2);
    idle(16);

    // Read then write (tRTW), then rank switch (tRTRS).
    casReq = 4'b0100; casRd = 4'b0100; casGroup = 8'b01_00_00_00; casRank = '0;
    run_until(2, 8, n);
    casReq = 4'b1000;
    run_until(3, 12, n); chk("t4_rtw", n, 3);
    idle(16);
    casReq = 4'b0001; casRd = 4'b0011; casGroup = '0; casRank = 8'b00_00_00_01;
    run_until(0, 8, n);
    casReq = 4'b0010;
    run_until(1, 12, n); chk("t4_rtrs", n, 2);
    idle(16);
    casReq = 4'b1000; casRd = 4'b1000; casRank = '0;
    run_until(3, 8, n);
    idle(16);

    // Four readers in distinct groups, with a stall window.
    casReq = 4'b1111; casRd = 4'b1111; casGroup = 8'b11_10_01_00; casRank = '0;
    run_until(0, 8, n); chk("t5_g0", n, 1);
    run_until(1, 8, n); chk("t5_g1", n, 1);
    casStall = 1'b1;
    repeat (3) begin
      step();
      chk("t5_stall", sel, 0);
    end
    casStall = 1'b0;
    step();
    chk("t5_resume", sel, 4'b0100);
    step();
    chk("t5_next", sel, 4'b1000);
    idle(4);

    // Reset during a grant drops outputs at once; pending request then wins.
    casReq = 4'b0010; casRd = 4'b1010;
    run_until(1, 8, n);
    casReq = 4'b1000;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_sel", sel, 0);
    chk("t6_grant", grant, 0);
    chk("t6_valid", casValid, 0);
    @(negedge clk);
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
    step();
    chk("t6_after", sel, 4'b1000);

    // Randomized traffic against the model.
    casReq = '0;
    idle(2);
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_sel[i]) begin
          if ($urandom_range(0, 1) == 1) casReq[i] = 1'b0;
          else newcmd(i);
        end else if (!casReq[i] && $urandom_range(0, 3) == 0) begin
          newcmd(i);
        end
      end
      casStall = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
